// File: rtl/ahb_sram_subordinate_if.sv
// rtl/ahb_sram_subordinate_if.sv - AHB subordinate-side bus signals for the SRAM responder
interface ahb_sram_subordinate_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    logic                   sel;
    logic [AddrWidth-1:0]   addr;
    logic [2:0]             trans;
    logic                   write;
    logic [3:0]             size;
    logic [DataWidth-1:0]   wData;
    logic [DataWidth/8-1:0] wStrb;
    logic                   ready;
    logic                   readyOut;
    logic                   resp;
    logic [DataWidth-1:0]   rData;

    modport master (
        output sel, addr, trans, write, size, wData, wStrb, ready,
        input  readyOut, resp, rData
    );

    modport slave (
        input  sel, addr, trans, write, size, wData, wStrb, ready,
        output readyOut, resp, rData
    );
endinterface

// File: rtl/ahb_sram_subordinate.sv
// rtl/ahb_sram_subordinate.sv - AHB subordinate fronting a word-addressed SRAM with wait states and two-cycle ERROR
// Optional AHB_SRAM_WSTRB_EN: write lanes additionally gated by wStrb.
module ahb_sram_subordinate #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 32,
    parameter int Depth      = 256,
    parameter int WaitStates = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    ahb_sram_subordinate_if.slave bus
);
    localparam int StrbW     = DataWidth / 8;
    localparam int ByteShift = $clog2(StrbW);
    localparam int OffW      = (ByteShift > 0) ? ByteShift : 1;
    localparam int MemAw     = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t               state, state_nx;
    logic [3:0]           wcnt, wcnt_nx;
    logic [MemAw-1:0]     dp_idx;
    logic [OffW-1:0]      dp_off;
    logic [2:0]           dp_size;
    logic                 dp_write;
    logic [DataWidth-1:0] mem [Depth];

    logic                 can_accept;
    logic                 accept;
    logic                 addr_err;
    logic                 commit;
    logic [AddrWidth-1:0] word_idx;
    logic [OffW-1:0]      addr_off;
    logic [StrbW-1:0]     lane_en;
    logic [StrbW-1:0]     wr_lanes;
    logic [DataWidth-1:0] lane_bits;

    assign word_idx   = bus.addr >> ByteShift;
    assign addr_off   = OffW'(bus.addr) & OffW'(StrbW - 1);
    assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign accept     = can_accept && bus.sel && bus.ready && bus.trans[1];
    assign commit     = (state == S_DATA) && dp_write && !reset;

    always_comb begin
        addr_err = 1'b0;
        if (word_idx >= AddrWidth'(Depth))
            addr_err = 1'b1;
        if (bus.size[3])
            addr_err = 1'b1;
        if (int'(bus.size[2:0]) > ByteShift)
            addr_err = 1'b1;
        if ((int'(addr_off) & ((1 << bus.size[2:0]) - 1)) != 0)
            addr_err = 1'b1;
    end

    // A lane belongs to the transfer when it differs from the start offset only in bits below size.
    always_comb begin
        lane_en   = '0;
        lane_bits = '0;
        for (int i = 0; i < StrbW; i++) begin
            lane_en[i]         = (((i ^ int'(dp_off)) >> dp_size) == 0);
            lane_bits[8*i +: 8] = {8{lane_en[i]}};
        end
    end

`ifdef AHB_SRAM_WSTRB_EN
    assign wr_lanes = lane_en & bus.wStrb;
    logic unused_bits;
    assign unused_bits = bus.trans[2];
`else
    assign wr_lanes = lane_en;
    logic unused_bits;
    assign unused_bits = ^{bus.trans[2], bus.wStrb};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            dp_idx   <= '0;
            dp_off   <= '0;
            dp_size  <= '0;
            dp_write <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            if (accept) begin
                dp_idx   <= MemAw'(word_idx);
                dp_off   <= addr_off;
                dp_size  <= bus.size[2:0];
                dp_write <= bus.write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < StrbW; i++) begin
                if (wr_lanes[i])
                    mem[dp_idx][8*i +: 8] <= bus.wData[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx     = state;
        wcnt_nx      = wcnt;
        bus.readyOut = 1'b1;
        bus.resp     = 1'b0;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                bus.resp = (state == S_ERR2);
                state_nx = S_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_nx = S_ERR1;
                    end else if (WaitStates > 0) begin
                        state_nx = S_WAIT;
                        wcnt_nx  = '0;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
            S_WAIT: begin
                bus.readyOut = 1'b0;
                if (wcnt == 4'(WaitStates - 1))
                    state_nx = S_DATA;
                else
                    wcnt_nx = wcnt + 4'd1;
            end
            S_ERR1: begin
                bus.readyOut = 1'b0;
                bus.resp     = 1'b1;
                state_nx     = S_ERR2;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.rData = '0;
        if (state == S_DATA && !dp_write)
            bus.rData = mem[dp_idx] & lane_bits;
    end
endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// tb/tb_ahb_sram_subordinate.sv - directed-vector bench for ahb_sram_subordinate (WaitStates 0 and 2)
module tb_ahb_sram_subordinate;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel_0 = 1'b0;
    logic        sel_2 = 1'b0;
    logic [31:0] m_addr = '0;
    logic [2:0]  m_trans = '0;
    logic        m_write = 1'b0;
    logic [3:0]  m_size = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wstrb = '0;

    int n_vec = 0;
    int n_bad = 0;

`ifdef AHB_SRAM_WSTRB_EN
    localparam logic [31:0] StrbExp     = 32'h00FF00FF;
    localparam logic [31:0] StrbZeroExp = 32'h00FF00FF;
`else
    localparam logic [31:0] StrbExp     = 32'hFFFFFFFF;
    localparam logic [31:0] StrbZeroExp = 32'h12345678;
`endif

    ahb_sram_subordinate_if #(.DataWidth(32), .AddrWidth(32)) b0 ();
    ahb_sram_subordinate_if #(.DataWidth(32), .AddrWidth(32)) b2 ();

    assign b0.sel   = sel_0;
    assign b0.addr  = m_addr;
    assign b0.trans = m_trans;
    assign b0.write = m_write;
    assign b0.size  = m_size;
    assign b0.wData = m_wdata;
    assign b0.wStrb = m_wstrb;
    assign b0.ready = b0.readyOut;

    assign b2.sel   = sel_2;
    assign b2.addr  = m_addr;
    assign b2.trans = m_trans;
    assign b2.write = m_write;
    assign b2.size  = m_size;
    assign b2.wData = m_wdata;
    assign b2.wStrb = m_wstrb;
    assign b2.ready = b2.readyOut;

    ahb_sram_subordinate #(.DataWidth(32), .AddrWidth(32), .Depth(256), .WaitStates(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    ahb_sram_subordinate #(.DataWidth(32), .AddrWidth(32), .Depth(256), .WaitStates(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated transfer; returns the completing cycle's resp/rData plus first-cycle response.
    task automatic xfer(input bit use2, input logic wr, input logic [31:0] a, input logic [3:0] sz,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic rs, output int ncyc,
                        output logic ro_first, output logic rs_first);
        logic ro;
        bit   done;
        @(posedge clk); #1;
        sel_0 = !use2; sel_2 = use2;
        m_trans = 3'b010; m_addr = a; m_write = wr; m_size = sz;
        @(posedge clk); #1;
        sel_0 = 1'b0; sel_2 = 1'b0; m_trans = 3'b000;
        m_wdata = wd; m_wstrb = st;
        ncyc = 0; rd = '0; rs = 1'b0; ro_first = 1'b0; rs_first = 1'b0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            ncyc++;
            ro = use2 ? b2.readyOut : b0.readyOut;
            if (ncyc == 1) begin
                ro_first = ro;
                rs_first = use2 ? b2.resp : b0.resp;
            end
            if (ro) begin
                rd   = use2 ? b2.rData : b0.rData;
                rs   = use2 ? b2.resp : b0.resp;
                done = 1'b1;
            end else if (ncyc >= 32) begin
                check("xfer_timeout", 64'(ncyc), 64'd0);
                done = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        rs, rof, rsf;
        int          nc;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ro0", b0.readyOut, 1);
        check("rst_rs0", b0.resp, 0);
        check("rst_rd0", b0.rData, 0);
        check("rst_ro2", b2.readyOut, 1);
        check("rst_rs2", b2.resp, 0);

        // Basic write then read, zero wait states
        xfer(0, 1, 32'h10, 4'd2, 32'hDEADBEEF, 4'hF, rd, rs, nc, rof, rsf);
        check("wr10_ro", rof, 1);
        check("wr10_cyc", nc, 1);
        check("wr10_rs", rs, 0);
        xfer(0, 0, 32'h10, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("rd10_cyc", nc, 1);
        check("rd10_data", rd, 32'hDEADBEEF);
        check("rd10_rs", rs, 0);

        // Out-of-range read and write: two-cycle ERROR, aliasing word 0 untouched
        xfer(0, 1, 32'h0, 4'd2, 32'h11111111, 4'hF, rd, rs, nc, rof, rsf);
        xfer(0, 0, 32'h400, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("err_rd_ro1", rof, 0);
        check("err_rd_rs1", rsf, 1);
        check("err_rd_rs2", rs, 1);
        check("err_rd_cyc", nc, 2);
        xfer(0, 1, 32'h400, 4'd2, 32'h99999999, 4'hF, rd, rs, nc, rof, rsf);
        check("err_wr_rs", rs, 1);
        xfer(0, 0, 32'h0, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("err_wr_nocommit", rd, 32'h11111111);

        // Last valid word
        xfer(0, 1, 32'h3FC, 4'd2, 32'h600DCAFE, 4'hF, rd, rs, nc, rof, rsf);
        check("last_wr_rs", rs, 0);
        xfer(0, 0, 32'h3FC, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("last_rd", rd, 32'h600DCAFE);

        // Byte lanes
        xfer(0, 1, 32'h10, 4'd2, 32'h11223344, 4'hF, rd, rs, nc, rof, rsf);
        xfer(0, 1, 32'h13, 4'd0, 32'hAB5A5A5A, 4'hF, rd, rs, nc, rof, rsf);
        check("byte_wr_rs", rs, 0);
        xfer(0, 0, 32'h10, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("byte_wr_word", rd, 32'hAB223344);
        xfer(0, 0, 32'h11, 4'd0, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("byte_rd_lane1", rd, 32'h00003300);
        xfer(0, 1, 32'h11, 4'd1, 32'hFFFFFFFF, 4'hF, rd, rs, nc, rof, rsf);
        check("half_misalign_rs", rs, 1);
        xfer(0, 0, 32'h10, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("half_misalign_nochg", rd, 32'hAB223344);
        xfer(0, 1, 32'h12, 4'd1, 32'hCAFE1234, 4'hF, rd, rs, nc, rof, rsf);
        xfer(0, 0, 32'h10, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("half_wr_word", rd, 32'hCAFE3344);

        // Size errors
        xfer(0, 0, 32'h8, 4'd3, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("size8_err", rs, 1);
        xfer(0, 0, 32'h8, 4'b1000, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("size_bit3_err", rs, 1);

        // Write strobes
        xfer(0, 1, 32'h20, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        xfer(0, 1, 32'h20, 4'd2, 32'hFFFFFFFF, 4'b0101, rd, rs, nc, rof, rsf);
        xfer(0, 0, 32'h20, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("strb_0101", rd, 64'(StrbExp));
        xfer(0, 1, 32'h20, 4'd2, 32'h12345678, 4'b0000, rd, rs, nc, rof, rsf);
        check("strb_zero_rs", rs, 0);
        xfer(0, 0, 32'h20, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("strb_zero", rd, 64'(StrbZeroExp));

        // BUSY transfer: no access, zero-wait OKAY
        @(posedge clk); #1;
        sel_0 = 1'b1; m_trans = 3'b001; m_write = 1'b1; m_addr = 32'h10; m_size = 4'd2;
        @(posedge clk); #1;
        sel_0 = 1'b0; m_trans = 3'b000; m_wdata = 32'h0;
        @(negedge clk);
        check("busy_ro", b0.readyOut, 1);
        check("busy_rs", b0.resp, 0);
        check("busy_rdata", b0.rData, 0);
        xfer(0, 0, 32'h10, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("busy_nochg", rd, 32'hCAFE3344);

        // Pipelined write then read of the same word
        @(posedge clk); #1;
        sel_0 = 1'b1; m_trans = 3'b010; m_write = 1'b1; m_addr = 32'h30; m_size = 4'd2;
        @(posedge clk); #1;
        m_trans = 3'b011; m_write = 1'b0; m_wdata = 32'h13579BDF; m_wstrb = 4'hF;
        @(negedge clk);
        check("pipe_wr_ro", b0.readyOut, 1);
        @(posedge clk); #1;
        sel_0 = 1'b0; m_trans = 3'b000;
        @(negedge clk);
        check("pipe_rd_ro", b0.readyOut, 1);
        check("pipe_rd_data", b0.rData, 32'h13579BDF);

        // Two wait states
        xfer(1, 1, 32'h4, 4'd2, 32'h55AA55AA, 4'hF, rd, rs, nc, rof, rsf);
        check("ws2_wr_cyc", nc, 3);
        xfer(1, 0, 32'h4, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("ws2_rd_ro1", rof, 0);
        check("ws2_rd_rs1", rsf, 0);
        check("ws2_rd_cyc", nc, 3);
        check("ws2_rd_rs", rs, 0);
        check("ws2_rd_data", rd, 32'h55AA55AA);

        // Reset during the wait of a write drops it
        @(posedge clk); #1;
        sel_2 = 1'b1; m_trans = 3'b010; m_write = 1'b1; m_addr = 32'h4; m_size = 4'd2;
        @(posedge clk); #1;
        sel_2 = 1'b0; m_trans = 3'b000; m_wdata = 32'h0BADF00D; m_wstrb = 4'hF;
        @(negedge clk);
        check("rstmid_wait_ro", b2.readyOut, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_ro", b2.readyOut, 1);
        check("rstmid_rs", b2.resp, 0);
        xfer(1, 0, 32'h4, 4'd2, 32'h0, 4'hF, rd, rs, nc, rof, rsf);
        check("rstmid_olddata", rd, 32'h55AA55AA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
